// File: rtl/dma_bridge_pkg.sv
// Shared types and helpers for the DMA line bridge: FSM state type, transfer
// mode encodings and line/word geometry functions.
package dma_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdWait,
    StLdWord,
    StStRd,
    StStWait,
    StStPush,
    StDone
  } bridge_state_e;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_STORE = 1'b1;

  function automatic int unsigned calc_wpl(int unsigned line_width, int unsigned word_width);
    return line_width / word_width;
  endfunction

  // Keep at least one bit so a single-word line still has a legal index.
  function automatic int unsigned calc_idx_width(int unsigned wpl);
    return (wpl > 1) ? $clog2(wpl) : 1;
  endfunction

endpackage

// File: rtl/line_packer.sv
// Line buffer for STORE: collects memory words into slots and presents the
// assembled line straight from the register to the host write FIFO.
module line_packer import dma_bridge_pkg::*; #(
  parameter int unsigned LINE_WIDTH = 512,
  parameter int unsigned WORD_WIDTH = 32,
  localparam int unsigned WPL = calc_wpl(LINE_WIDTH, WORD_WIDTH),
  localparam int unsigned IDX_W = calc_idx_width(WPL)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_slot,
  input  logic [WORD_WIDTH-1:0] wr_word,
  output logic [LINE_WIDTH-1:0] line
);

  logic [WPL-1:0][WORD_WIDTH-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (wr_en) begin
      line_q[wr_slot] <= wr_word;
    end
  end

  assign line = line_q;

endmodule

// File: rtl/dma_line_bridge.sv
// Moves host cache lines to/from the word-wide memory port (LOAD unpacks, STORE packs).
// Optional DMA_LINE_BRIDGE_CHECKSUM_EN adds a per-job XOR checksum output.
module dma_line_bridge import dma_bridge_pkg::*; #(
  parameter int unsigned LINE_WIDTH  = 512,
  parameter int unsigned WORD_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 28,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [COUNT_WIDTH-1:0] num_lines,
  output logic                   busy,
  output logic                   done,
  input  logic                   host_empty,
  input  logic [LINE_WIDTH-1:0]  host_rd_data,
  output logic                   host_rd_en,
  input  logic                   host_full,
  output logic [LINE_WIDTH-1:0]  host_wr_data,
  output logic                   host_wr_en,
  output logic                   mem_en,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WORD_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready,
  input  logic [WORD_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_rvalid
`ifdef DMA_LINE_BRIDGE_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0]  checksum
`endif
);

  localparam int unsigned WPL   = calc_wpl(LINE_WIDTH, WORD_WIDTH);
  localparam int unsigned IDX_W = calc_idx_width(WPL);

  bridge_state_e          state_q, state_d;
  logic [IDX_W-1:0]       word_idx_q, word_idx_d;
  logic [COUNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [COUNT_WIDTH-1:0] num_lines_q, num_lines_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   last_word, last_line, line_wr;

  logic [WPL-1:0][WORD_WIDTH-1:0] rd_words;
  assign rd_words = host_rd_data;

  assign last_word = (word_idx_q == IDX_W'(WPL - 1));
  assign last_line = ((line_cnt_q + COUNT_WIDTH'(1)) == num_lines_q);
  assign mem_addr  = addr_q;

  always_comb begin
    state_d     = state_q;
    word_idx_d  = word_idx_q;
    line_cnt_d  = line_cnt_q;
    num_lines_d = num_lines_q;
    addr_d      = addr_q;
    busy        = (state_q != StIdle);
    done        = 1'b0;
    host_rd_en  = 1'b0;
    host_wr_en  = 1'b0;
    mem_en      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    line_wr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_lines_d = num_lines;
          addr_d      = base_addr;
          word_idx_d  = '0;
          line_cnt_d  = '0;
          if (num_lines == '0)        state_d = StDone;
          else if (mode == MODE_LOAD) state_d = StLdWait;
          else                        state_d = StStRd;
        end
      end
      StLdWait: begin
        if (!host_empty) state_d = StLdWord;
      end
      StLdWord: begin
        mem_en    = 1'b1;
        mem_wr_en = 1'b1;
        mem_wdata = rd_words[word_idx_q];
        if (mem_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (last_word) begin
            // Head line fully written: pop it in the same cycle as its last word.
            host_rd_en = 1'b1;
            word_idx_d = '0;
            line_cnt_d = line_cnt_q + COUNT_WIDTH'(1);
            state_d    = last_line ? StDone : StLdWait;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end
      end
      StStRd: begin
        mem_en = 1'b1;
        if (mem_ready) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = StStWait;
        end
      end
      StStWait: begin
        if (mem_rvalid) begin
          line_wr = 1'b1;
          if (last_word) begin
            word_idx_d = '0;
            state_d    = StStPush;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
            state_d    = StStRd;
          end
        end
      end
      StStPush: begin
        if (!host_full) begin
          host_wr_en = 1'b1;
          line_cnt_d = line_cnt_q + COUNT_WIDTH'(1);
          state_d    = last_line ? StDone : StStRd;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      word_idx_q  <= '0;
      line_cnt_q  <= '0;
      num_lines_q <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      line_cnt_q  <= line_cnt_d;
      num_lines_q <= num_lines_d;
      addr_q      <= addr_d;
    end
  end

  line_packer #(
    .LINE_WIDTH(LINE_WIDTH),
    .WORD_WIDTH(WORD_WIDTH)
  ) u_line_packer (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (line_wr),
    .wr_slot(word_idx_q),
    .wr_word(mem_rdata),
    .line   (host_wr_data)
  );

`ifdef DMA_LINE_BRIDGE_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StIdle && start) begin
      checksum_d = '0;
    end else if (state_q == StLdWord && mem_ready) begin
      checksum_d = checksum_q ^ mem_wdata;
    end else if (line_wr) begin
      checksum_d = checksum_q ^ mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) checksum_q <= '0;
    else        checksum_q <= checksum_d;
  end

  assign checksum = checksum_q;
`endif

endmodule
